// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver: synchronises and glitch-filters the PS/2 lines, deframes 11-bit frames,
// and queues good bytes in a first-word-fall-through FIFO with a valid/ready output.
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 8,
  parameter int FIFO_AW        = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overflow
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s;
  logic                   filt_clk, filt_prev;
  logic [FCW-1:0]         filt_cnt;
  logic                   sample;

  state_t                 state, state_d;
  logic [2:0]             bit_cnt, bit_cnt_d;
  logic [7:0]             shreg, shreg_d;
  logic                   par_bit, par_d;
  logic [TCW-1:0]         to_cnt;
  logic                   timeout, push, perr, ferr;

  logic [7:0]             mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]     wr_ptr, rd_ptr;
  logic                   full, pop, do_push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // The filtered level only follows the line after FILTER_LEN consecutive disagreeing cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FCW'(1);
      end
    end
  end

  assign sample = filt_prev & ~filt_clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      par_bit <= par_d;
      if (state == IDLE || sample || timeout)
        to_cnt <= '0;
      else
        to_cnt <= to_cnt + TCW'(1);
    end
  end

  // A sample event in the same cycle as the timeout limit wins, since it proves the line is alive.
  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    par_d     = par_bit;
    push      = 1'b0;
    perr      = 1'b0;
    ferr      = 1'b0;
    timeout   = (state != IDLE) && !sample && (to_cnt == TCW'(TIMEOUT_CYCLES - 1));
    if (timeout) begin
      state_d = IDLE;
      ferr    = 1'b1;
    end else if (sample) begin
      case (state)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shreg_d[bit_cnt] = data_s;
          if (bit_cnt == 3'd7)
            state_d = PARITY;
          else
            bit_cnt_d = bit_cnt + 3'd1;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          ferr    = !data_s;
          perr    = !(^{shreg, par_bit});
          push    = data_s && (^{shreg, par_bit});
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign full      = (fifo_count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign do_push   = push & (~full | pop);
  assign out_data  = out_valid ? mem[rd_ptr] : 8'h00;

  // Storage is not reset; out_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= perr;
      frame_err  <= ferr;
      overflow   <= push & full & ~pop;
      if (do_push)
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_AW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_AW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
